// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: RV32I load/store
// funct3 encodings, FSM state type, access sizes and the operation payload.
package dmem_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned CNT_W    = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Word-independent part of an access as seen by the lane logic
  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [1:0]      lane;
    logic [XLEN-1:0] wdata;
  } dmem_op_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic: funct3 decode, store byte enables and
// lane replication, load extraction with sign/zero extension, fault detect.
// Build option: DMEM_MISALIGN_TRAP_EN turns misaligned and illegal-funct3
// accesses into faults; otherwise they are silently aligned / treated as word.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wword_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            fault_c
);

  size_e           size;
  logic            uns;
  logic            illegal;
  logic [1:0]      off;
  logic [XLEN-1:0] shifted;

  // Decode funct3 into size/signedness; unknown encodings fall back to word
  always_comb begin
    size    = SZ_W;
    uns     = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_B:    size = SZ_B;
      F3_H:    size = SZ_H;
      F3_W:    size = SZ_W;
      F3_BU:   begin size = SZ_B; uns = 1'b1; illegal = we; end
      F3_HU:   begin size = SZ_H; uns = 1'b1; illegal = we; end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      size = SZ_W;
      uns  = 1'b0;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign fault_c = illegal
                 | ((size == SZ_H) && lane[0])
                 | ((size == SZ_W) && (lane != 2'b00));
`else
  assign fault_c = 1'b0;
`endif

  // Effective byte offset: halfwords drop addr[0], words drop addr[1:0]
  always_comb begin
    off = 2'b00;
    case (size)
      SZ_B:    off = lane;
      SZ_H:    off = {lane[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  // Store path: replicate data across lanes, enable only the addressed ones
  always_comb begin
    be_c    = 4'b0000;
    wword_c = wdata;
    case (size)
      SZ_B: begin
        be_c    = 4'b0001 << off;
        wword_c = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be_c    = 4'b0011 << off;
        wword_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wword_c = wdata;
      end
    endcase
    if (!we || fault_c) be_c = 4'b0000;
  end

  assign shifted = rword >> {off, 3'b000};

  // Load path: extract and extend; stores and faults return zero
  always_comb begin
    rdata_c = shifted;
    case (size)
      SZ_B: rdata_c = uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                          : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_H: rdata_c = uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                          : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default: rdata_c = shifted;
    endcase
    if (we || fault_c) rdata_c = '0;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single-outstanding load/store with configurable
// wait latency, byte-lane access to a word array, one-cycle done pulse.
// Build option: DMEM_MISALIGN_TRAP_EN (see dmem_lane_unit) enables faults.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              fault
);

  localparam int unsigned WORD_W    = ADDR_W - 2;
  localparam int unsigned DEPTH     = 2 ** WORD_W;
  localparam bit          SKIP_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  if (DATA_W != XLEN) begin : g_bad_data_w
    $error("data_mem_ctrl: DATA_W must be 32");
  end
  if (WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("data_mem_ctrl: WAIT_CYCLES must be 0..15");
  end

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  dmem_op_t          cap_op;
  logic [WORD_W-1:0] cap_word;

  dmem_op_t          live_op;
  dmem_op_t          op;
  logic [WORD_W-1:0] op_word;
  logic              enter_resp_c;

  logic [XLEN-1:0]   mem [DEPTH];
  logic [XLEN-1:0]   rword;
  logic [3:0]        be_c;
  logic [XLEN-1:0]   wword_c;
  logic [XLEN-1:0]   rdata_c;
  logic              fault_c;

  assign live_op = '{we: we, funct3: funct3, lane: addr[1:0], wdata: wdata};

  // With zero wait the access completes on the accept edge, so use live inputs
  assign op      = (state == S_IDLE) ? live_op : cap_op;
  assign op_word = (state == S_IDLE) ? addr[ADDR_W-1:2] : cap_word;
  assign rword   = mem[op_word];

  assign enter_resp_c = ((state == S_IDLE) && req && SKIP_WAIT)
                      || ((state == S_WAIT) && (cnt == CNT_W'(1)));

  dmem_lane_unit u_lane (
    .we      (op.we),
    .funct3  (op.funct3),
    .lane    (op.lane),
    .wdata   (op.wdata),
    .rword   (rword),
    .be_c    (be_c),
    .wword_c (wword_c),
    .rdata_c (rdata_c),
    .fault_c (fault_c)
  );

  // Access sequencing: IDLE accepts, WAIT counts down, RESP pulses done
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cap_op   <= '0;
      cap_word <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      rdata    <= '0;
      fault    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_op   <= live_op;
            cap_word <= addr[ADDR_W-1:2];
            ready    <= 1'b0;
            if (SKIP_WAIT) begin
              state <= S_RESP;
              done  <= 1'b1;
              rdata <= rdata_c;
              fault <= fault_c;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            state <= S_RESP;
            cnt   <= '0;
            done  <= 1'b1;
            rdata <= rdata_c;
            fault <= fault_c;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b1;
          rdata <= '0;
          fault <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

  // Store commit on the edge entering RESP; array contents survive reset
  always_ff @(posedge clk) begin
    if (enter_resp_c && reset_n) begin
      for (int b = 0; b < 4; b++) begin
        if (be_c[b]) mem[op_word][8*b +: 8] <= wword_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: three instances with WAIT_CYCLES
// 0, 1 and 3 share the data inputs and reset; each has its own req.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        req_v   [3];
  logic        we;
  logic [2:0]  funct3;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic        ready_v [3];
  logic        done_v  [3];
  logic [31:0] rdata_v [3];
  logic        fault_v [3];

  int   checks;
  int   errors;
  int   done_cnt [3];
  exp_t sb [$];

  data_mem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req(req_v[0]), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready_v[0]), .done(done_v[0]),
    .rdata(rdata_v[0]), .fault(fault_v[0]));

  data_mem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(req_v[1]), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready_v[1]), .done(done_v[1]),
    .rdata(rdata_v[1]), .fault(fault_v[1]));

  data_mem_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req(req_v[2]), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready_v[2]), .done(done_v[2]),
    .rdata(rdata_v[2]), .fault(fault_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses per instance
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) done_cnt[i]++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access on instance d; expectation queued at drive, popped at done
  task automatic access(input int d, input logic w, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef, input bit hold);
    exp_t e;
    exp_t got;
    int   n;
    bit   seen;
    @(negedge clk);
    check($sformatf("ready_idle d%0d a%03h", d, a), 32'(ready_v[d]), 32'd1);
    e.rdata = er;
    e.fault = ef;
    e.lat   = lat_of(d);
    sb.push_back(e);
    we = w; funct3 = f3; addr = a; wdata = wd; req_v[d] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!hold) req_v[d] = 1'b0;
      if (done_v[d] === 1'b1) begin
        seen = 1'b1;
        req_v[d] = 1'b0;
        got = sb.pop_front();
        check($sformatf("latency d%0d a%03h", d, a), 32'(n), 32'(got.lat));
        check($sformatf("rdata d%0d a%03h", d, a), rdata_v[d], got.rdata);
        check($sformatf("fault d%0d a%03h", d, a), 32'(fault_v[d]), 32'(got.fault));
      end else if (n == 1) begin
        check($sformatf("busy d%0d a%03h", d, a), 32'(ready_v[d]), 32'd0);
      end
    end
    if (!seen) begin
      check($sformatf("timeout d%0d a%03h", d, a), 32'd0, 32'd1);
      void'(sb.pop_back());
      req_v[d] = 1'b0;
    end
    @(negedge clk);
    check($sformatf("done_one_cycle d%0d", d), 32'(done_v[d]), 32'd0);
    check($sformatf("ready_after d%0d", d), 32'(ready_v[d]), 32'd1);
  endtask

  initial begin
    int c0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      req_v[i] = 1'b0;
      done_cnt[i] = 0;
    end
    we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    reset_n = 1'b0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready d%0d", i), 32'(ready_v[i]), 32'd1);
      check($sformatf("rst_done d%0d", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst_rdata d%0d", i), rdata_v[i], 32'd0);
      check($sformatf("rst_fault d%0d", i), 32'(fault_v[i]), 32'd0);
    end
    reset_n = 1'b1;

    // Word store/load round trip
    access(1, 1'b1, F3_W, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    access(1, 1'b0, F3_W, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

    // Byte store into lane 3, signed/unsigned byte loads, merged word
    access(1, 1'b1, F3_B, 9'h013, 32'hAAAAAA80, 32'h0, 1'b0, 1'b0);
    access(1, 1'b0, F3_B,  9'h013, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0);
    access(1, 1'b0, F3_BU, 9'h013, 32'h0, 32'h00000080, 1'b0, 1'b0);
    access(1, 1'b0, F3_W,  9'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0);

    // Halfword store into upper half, halfword/byte loads
    access(1, 1'b1, F3_W, 9'h020, 32'h89ABCDEF, 32'h0, 1'b0, 1'b0);
    access(1, 1'b1, F3_H, 9'h022, 32'hFFFF1234, 32'h0, 1'b0, 1'b0);
    access(1, 1'b0, F3_HU, 9'h022, 32'h0, 32'h00001234, 1'b0, 1'b0);
    access(1, 1'b0, F3_H,  9'h020, 32'h0, 32'hFFFFCDEF, 1'b0, 1'b0);
    access(1, 1'b0, F3_HU, 9'h020, 32'h0, 32'h0000CDEF, 1'b0, 1'b0);
    access(1, 1'b0, F3_B,  9'h021, 32'h0, 32'hFFFFFFCD, 1'b0, 1'b0);

    // Misaligned and illegal-funct3 accesses
    access(1, 1'b1, F3_W, 9'h030, 32'h11111111, 32'h0, 1'b0, 1'b0);
    access(1, 1'b1, F3_W, 9'h040, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    access(1, 1'b1, F3_W, 9'h031, 32'h55667788, 32'h0, 1'b1, 1'b0);
    access(1, 1'b0, F3_W, 9'h030, 32'h0, 32'h11111111, 1'b0, 1'b0);
    access(1, 1'b0, F3_H, 9'h021, 32'h0, 32'h0, 1'b1, 1'b0);
    access(1, 1'b0, 3'b011, 9'h012, 32'h0, 32'h0, 1'b1, 1'b0);
    access(1, 1'b1, F3_BU, 9'h040, 32'h12345678, 32'h0, 1'b1, 1'b0);
    access(1, 1'b0, F3_W, 9'h040, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
`else
    access(1, 1'b1, F3_W, 9'h031, 32'h55667788, 32'h0, 1'b0, 1'b0);
    access(1, 1'b0, F3_W, 9'h030, 32'h0, 32'h55667788, 1'b0, 1'b0);
    access(1, 1'b0, F3_H, 9'h021, 32'h0, 32'hFFFFCDEF, 1'b0, 1'b0);
    access(1, 1'b0, 3'b011, 9'h012, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0);
    access(1, 1'b1, F3_BU, 9'h040, 32'h12345678, 32'h0, 1'b0, 1'b0);
    access(1, 1'b0, F3_W, 9'h040, 32'h0, 32'h12345678, 1'b0, 1'b0);
`endif

    // req held high through a busy access: exactly one access
    c0 = done_cnt[1];
    access(1, 1'b1, F3_W, 9'h060, 32'h0BADF00D, 32'h0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_one_done", 32'(done_cnt[1] - c0), 32'd1);
    access(1, 1'b0, F3_W, 9'h060, 32'h0, 32'h0BADF00D, 1'b0, 1'b0);

    // Zero-wait instance
    access(0, 1'b1, F3_W, 9'h0F0, 32'hCAFEBABE, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, F3_W, 9'h0F0, 32'h0, 32'hCAFEBABE, 1'b0, 1'b0);
    access(0, 1'b1, F3_B, 9'h0F1, 32'h0000007F, 32'h0, 1'b0, 1'b0);
    access(0, 1'b0, F3_B, 9'h0F1, 32'h0, 32'h0000007F, 1'b0, 1'b0);
    access(0, 1'b0, F3_W, 9'h0F0, 32'h0, 32'hCAFE7FBE, 1'b0, 1'b0);
    access(0, 1'b0, F3_H, 9'h0F2, 32'h0, 32'hFFFFCAFE, 1'b0, 1'b0);

    // Three-wait instance: reset mid-access abandons the store
    access(2, 1'b1, F3_W, 9'h050, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    we = 1'b1; funct3 = F3_W; addr = 9'h050; wdata = 32'h5A5A5A5A; req_v[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_v[2] = 1'b0;
    check("rst_mid_busy", 32'(ready_v[2]), 32'd0);
    c0 = done_cnt[2];
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(ready_v[2]), 32'd1);
    check("rst_mid_done", 32'(done_v[2]), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_mid_no_done", 32'(done_cnt[2] - c0), 32'd0);
    access(2, 1'b0, F3_W, 9'h050, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0);
    access(2, 1'b0, F3_HU, 9'h052, 32'h0, 32'h0000A5A5, 1'b0, 1'b0);

    // Earlier data in the W=1 instance survived the reset
    access(1, 1'b0, F3_W, 9'h010, 32'h0, 32'h80ADBEEF, 1'b0, 1'b0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning byte-address width; word depth = 2**(ADDR_W-2).
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; only 32 is legal and any other value SHALL cause an elaboration error.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, meaning added access latency; legal range 0..15.
REQ-004 SHALL have ports, one clock and asynchronous active-low reset:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req  input  1  access request.
- we  input  1  1=store, 0=load.
- funct3  input  3  RV32I load/store funct3.
- addr  input  ADDR_W  byte address.
- wdata  input  DATA_W  store data, right-aligned.
- ready  output  1  controller idle, can accept.
- done  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  load result, valid while done=1.
- fault  output  1  misaligned/illegal access, valid while done=1.

Function
REQ-005 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; ready=1 only in IDLE.
REQ-006 SHALL accept a request on a rising edge where req=1 and ready=1, capturing we, funct3, addr and wdata.
REQ-007 SHALL ignore req while ready=0; no queuing.
REQ-008 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter; WAIT_CYCLES=0 SHALL skip WAIT and go directly to RESP.
REQ-009 SHALL commit stores to the array on the edge entering RESP, and SHALL read loads from the array on that same edge.
REQ-010 SHALL hold done=1 for exactly the one RESP cycle; latency from accept edge to done = WAIT_CYCLES+1 cycles.
REQ-011 SHALL enable byte lanes as follows: SB = lane addr[1:0], wdata[7:0]; SH = lanes {addr[1],0} and {addr[1],1}, wdata[15:0]; SW = all four lanes.
REQ-012 SHALL build loads by shifting the word right by 8*addr[1:0]; LB/LH sign-extend and LBU/LHU zero-extend; LW returns the word unchanged.
REQ-013 SHALL return, for a load issued after a store to the same word, the stored data.
REQ-014 SHALL drive rdata=0 for stores and for faulted accesses.
REQ-015 SHALL leave the array unmodified on a faulted store.

Reset
REQ-016 SHALL, while reset_n=0, force state=IDLE, counter=0, done=0, rdata=0 and fault=0; ready=1 after reset.
REQ-017 SHALL abandon an in-flight access on reset mid-operation: no store commit and no done pulse.
REQ-018 SHALL NOT reset array contents.

Configuration
REQ-019 SHALL, with DMEM_MISALIGN_TRAP_EN defined:
- LH/LHU/SH with addr[0]=1 set fault=1.
- LW/SW with addr[1:0]!=0 set fault=1.
- funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores sets fault=1.
REQ-020 SHALL, without DMEM_MISALIGN_TRAP_EN:
- tie fault to 0.
- ignore addr[0] for halfwords and addr[1:0] for words.
- treat illegal funct3 as LW/SW.

Structure
REQ-021 SHALL take the following from shared package dmem_pkg: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), the FSM state typedef and MAX_WAIT=15.
REQ-022 SHALL place lane logic (byte-enable, store alignment, load extract/extend) in combinational sub-module dmem_lane_unit; the FSM, counter and array SHALL stay in data_mem_ctrl.

Verification
REQ-023 SHALL pass: with WAIT_CYCLES=1, SW 0xDEADBEEF @0x010, then LW @0x010 -> done exactly 2 cycles after each accept, rdata=0xDEADBEEF, fault=0.
REQ-024 SHALL pass: SB 0x80 @0x013, then LB @0x013 -> 0xFFFFFF80; LBU @0x013 -> 0x00000080; LW @0x010 -> 0x80ADBEEF.
REQ-025 SHALL pass: SH 0x1234 @0x022, then LHU @0x022 -> 0x00001234; LH @0x020 -> sign-extended lower half.
REQ-026 SHALL pass: with macro, SW @0x031 -> fault=1, rdata=0, and a subsequent LW @0x030 returns the prior contents; without macro, fault=0 and the word @0x030 is written.
REQ-027 SHALL pass: with WAIT_CYCLES=3, SW accepted then reset_n=0 in cycle 2 -> no done pulse, ready=1 after release, LW to the same word returns the old data.
REQ-028 SHALL pass: req held high through a busy access -> exactly one access performed and done pulses once.
